// File: rtl/teatris_sequenciador_jogadas.sv
// Play sequencer: the player must press the buttons in the order stored in a
// small sequence memory. Each play is a rising edge of the button vector; a
// play is judged one cycle after capture and reported with one-cycle pulses.
module teatris_sequenciador_jogadas #(
    parameter int N_BOTOES       = 4,
    parameter int PROFUNDIDADE   = 16,
    parameter int CICLOS_TIMEOUT = 5000,
    localparam int AW            = $clog2(PROFUNDIDADE)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                iniciar,
    input  logic                modo_repete,
    input  logic [AW:0]         tamanho,
    input  logic                carga_en,
    input  logic [AW-1:0]       carga_end,
    input  logic [N_BOTOES-1:0] carga_dado,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic                fim_sequencia,
    output logic                ocupado,
    output logic [AW-1:0]       db_contagem,
    output logic [N_BOTOES-1:0] db_jogada,
    output logic [N_BOTOES-1:0] db_esperado,
    output logic [3:0]          db_erros,
    output logic [2:0]          db_estado
);

    localparam int          TW         = $clog2(CICLOS_TIMEOUT);
    localparam logic [TW-1:0] TIMER_FIM = TW'(CICLOS_TIMEOUT - 1);
    localparam logic [AW:0] TAM_MAX    = (AW+1)'(PROFUNDIDADE);
    localparam logic [AW:0] TAM_UM     = (AW+1)'(1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        ESPERA  = 3'd1,
        COMPARA = 3'd2,
        FIM     = 3'd3,
        ERRO    = 3'd4
    } estado_t;

    estado_t             estado, estado_nxt;
    logic [AW-1:0]       endereco, endereco_nxt;
    logic [TW-1:0]       timer, timer_nxt;
    logic [AW:0]         tam_reg, tam_nxt;
    logic [N_BOTOES-1:0] jogada_nxt;
    logic [N_BOTOES-1:0] botoes_ant;
    logic [3:0]          erros_nxt;
    logic                acertou_nxt, errou_nxt, timeout_nxt, fim_nxt;

    logic [N_BOTOES-1:0] mem [PROFUNDIDADE];

    logic tem_jogada;
    logic inicio_aceito;
    logic jogada_ok;
    logic ultimo;

    // Sequence memory: loadable only while idle.
    // NOTE: the memory array has no reset on purpose, so its contents survive a reset.
    always_ff @(posedge clock) begin
        if (carga_en && (estado == OCIOSO))
            mem[carga_end] <= carga_dado;
    end

    assign db_esperado = mem[endereco];
    assign tem_jogada  = (botoes != '0) && (botoes_ant == '0);
    assign jogada_ok   = (db_jogada == db_esperado) && (db_jogada != '0)
                         && ((db_jogada & (db_jogada - 1'b1)) == '0);
    assign ultimo      = ({1'b0, endereco} == (tam_reg - TAM_UM));
    assign inicio_aceito = iniciar && (tamanho != '0)
                         && ((estado == OCIOSO) || (estado == FIM) || (estado == ERRO));

    // Next-state and next-output logic for the play FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        estado_nxt   = estado;
        endereco_nxt = endereco;
        timer_nxt    = timer;
        tam_nxt      = tam_reg;
        jogada_nxt   = db_jogada;
        erros_nxt    = db_erros;
        acertou_nxt  = 1'b0;
        errou_nxt    = 1'b0;
        timeout_nxt  = 1'b0;
        fim_nxt      = 1'b0;

        case (estado)
            OCIOSO: ;
            ESPERA: begin
                timer_nxt = timer + 1'b1;
                if (tem_jogada) begin
                    // A play arriving on the expiry cycle still counts.
                    jogada_nxt = botoes;
                    estado_nxt = COMPARA;
                end else if (timer == TIMER_FIM) begin
                    timeout_nxt = 1'b1;
                    estado_nxt  = ERRO;
                    if (db_erros != 4'hF) erros_nxt = db_erros + 1'b1;
                end
            end
            COMPARA: begin
                if (jogada_ok) begin
                    acertou_nxt = 1'b1;
                    if (ultimo) begin
                        fim_nxt    = 1'b1;
                        estado_nxt = FIM;
                    end else begin
                        endereco_nxt = endereco + 1'b1;
                        timer_nxt    = '0;
                        estado_nxt   = ESPERA;
                    end
                end else begin
                    errou_nxt  = 1'b1;
                    estado_nxt = ERRO;
                    if (db_erros != 4'hF) erros_nxt = db_erros + 1'b1;
                end
            end
            FIM: ;
            ERRO: begin
                if (modo_repete) begin
                    timer_nxt  = '0;
                    estado_nxt = ESPERA;
                end
            end
            default: estado_nxt = OCIOSO;
        endcase

        // An accepted start overrides whatever the idle/end states would do.
        if (inicio_aceito) begin
            estado_nxt   = ESPERA;
            endereco_nxt = '0;
            timer_nxt    = '0;
            erros_nxt    = '0;
            tam_nxt      = (tamanho > TAM_MAX) ? TAM_MAX : tamanho;
        end
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= OCIOSO;
            endereco      <= '0;
            timer         <= '0;
            tam_reg       <= '0;
            db_jogada     <= '0;
            botoes_ant    <= '0;
            db_erros      <= '0;
            acertou       <= 1'b0;
            errou         <= 1'b0;
            timeout       <= 1'b0;
            fim_sequencia <= 1'b0;
        end else begin
            estado        <= estado_nxt;
            endereco      <= endereco_nxt;
            timer         <= timer_nxt;
            tam_reg       <= tam_nxt;
            db_jogada     <= jogada_nxt;
            botoes_ant    <= botoes;
            db_erros      <= erros_nxt;
            acertou       <= acertou_nxt;
            errou         <= errou_nxt;
            timeout       <= timeout_nxt;
            fim_sequencia <= fim_nxt;
        end
    end

    assign ocupado     = (estado == ESPERA) || (estado == COMPARA);
    assign db_contagem = endereco;
    assign db_estado   = estado;

endmodule

// File: tb/tb_teatris_sequenciador_jogadas.sv
// Directed bench for the play sequencer: a vector table for the main flow and
// hand-written sequences for held buttons, timeouts, reset and boundaries.
module tb_teatris_sequenciador_jogadas;

    localparam int N  = 4;
    localparam int P  = 16;
    localparam int CT = 8;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  botoes;
    logic          iniciar;
    logic          modo_repete;
    logic [AW:0]   tamanho;
    logic          carga_en;
    logic [AW-1:0] carga_end;
    logic [N-1:0]  carga_dado;
    logic          acertou, errou, timeout, fim_sequencia, ocupado;
    logic [AW-1:0] db_contagem;
    logic [N-1:0]  db_jogada, db_esperado;
    logic [3:0]    db_erros;
    logic [2:0]    db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] exp_mem [P];

    typedef struct {
        logic [3:0] botoes;
        logic       iniciar;
        logic       repete;
        logic [4:0] tamanho;
        logic       ac, er, to, fim;
        logic [2:0] estado;
        logic [3:0] cont;
        logic [3:0] erros;
    } vec_t;

    vec_t vecs [17];

    teatris_sequenciador_jogadas #(
        .N_BOTOES(N), .PROFUNDIDADE(P), .CICLOS_TIMEOUT(CT)
    ) dut (
        .clock(clock), .reset(reset), .botoes(botoes), .iniciar(iniciar),
        .modo_repete(modo_repete), .tamanho(tamanho), .carga_en(carga_en),
        .carga_end(carga_end), .carga_dado(carga_dado), .acertou(acertou),
        .errou(errou), .timeout(timeout), .fim_sequencia(fim_sequencia),
        .ocupado(ocupado), .db_contagem(db_contagem), .db_jogada(db_jogada),
        .db_esperado(db_esperado), .db_erros(db_erros), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input int addr, input logic [N-1:0] data);
        carga_en   = 1'b1;
        carga_end  = AW'(addr);
        carga_dado = data;
        tick();
        carga_en   = 1'b0;
    endtask

    // Press, release; afterwards the verdict pulse of the play is visible.
    task automatic press(input logic [N-1:0] v);
        botoes = v;
        tick();
        botoes = '0;
        tick();
    endtask

    task automatic start(input logic [4:0] tam);
        iniciar = 1'b1;
        tamanho = tam;
        tick();
        iniciar = 1'b0;
    endtask

    initial begin
        int n_ac;
        reset = 1'b1; botoes = '0; iniciar = 1'b0; modo_repete = 1'b0;
        tamanho = '0; carga_en = 1'b0; carga_end = '0; carga_dado = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state.
        check("rst_estado", db_estado, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_pulses", {acertou, errou, timeout, fim_sequencia}, 0);
        check("rst_cont", db_contagem, 0);
        check("rst_erros", db_erros, 0);

        for (int i = 0; i < P; i++) exp_mem[i] = 4'b0001 << (i % 4);
        exp_mem[0] = 4'b0001; exp_mem[1] = 4'b0100; exp_mem[2] = 4'b1000;
        for (int i = 0; i < P; i++) load(i, exp_mem[i]);
        check("load_mem0", db_esperado, exp_mem[0]);

        //              botoes  ini  rep  tam    ac   er   to   fim  est   cont  erros
        vecs[0]  = '{4'b0000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0};
        vecs[1]  = '{4'b0000, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0, 4'd0};
        vecs[2]  = '{4'b0001, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0, 4'd0};
        vecs[3]  = '{4'b0000, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd1, 4'd0};
        vecs[4]  = '{4'b0100, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'd1, 4'd0};
        vecs[5]  = '{4'b0000, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd2, 4'd0};
        vecs[6]  = '{4'b1000, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'd2, 4'd0};
        vecs[7]  = '{4'b0000, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 4'd2, 4'd0};
        vecs[8]  = '{4'b0000, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'd2, 4'd0};
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0, 4'd0};
        vecs[10] = '{4'b0010, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0, 4'd0};
        vecs[11] = '{4'b0000, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 4'd0, 4'd1};
        vecs[12] = '{4'b0000, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 4'd0, 4'd1};
        vecs[13] = '{4'b0000, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0, 4'd0};
        vecs[14] = '{4'b0001, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0, 4'd0};
        vecs[15] = '{4'b0000, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd1, 4'd0};
        vecs[16] = '{4'b0000, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd1, 4'd0};

        for (int i = 0; i < 17; i++) begin
            botoes      = vecs[i].botoes;
            iniciar     = vecs[i].iniciar;
            modo_repete = vecs[i].repete;
            tamanho     = vecs[i].tamanho;
            tick();
            check($sformatf("v%0d_acertou", i), acertou, vecs[i].ac);
            check($sformatf("v%0d_errou", i), errou, vecs[i].er);
            check($sformatf("v%0d_timeout", i), timeout, vecs[i].to);
            check($sformatf("v%0d_fim", i), fim_sequencia, vecs[i].fim);
            check($sformatf("v%0d_estado", i), db_estado, vecs[i].estado);
            check($sformatf("v%0d_cont", i), db_contagem, vecs[i].cont);
            check($sformatf("v%0d_erros", i), db_erros, vecs[i].erros);
            check($sformatf("v%0d_ocupado", i), ocupado,
                  (vecs[i].estado == 3'd1) || (vecs[i].estado == 3'd2));
        end
        iniciar = 1'b0;

        // Held button at address 1 yields exactly one hit.
        botoes = 4'b0100;
        n_ac = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (acertou) n_ac++;
        end
        botoes = '0;
        tick();
        if (acertou) n_ac++;
        check("held_hits", n_ac, 1);
        check("held_cont", db_contagem, 2);
        check("held_estado", db_estado, 1);

        // Timeouts with retry at the same address, saturating error count.
        do_reset();
        modo_repete = 1'b1;
        start(5'd3);
        check("to_start_estado", db_estado, 1);
        press(exp_mem[0]);
        check("to_pre_acertou", acertou, 1);
        for (int k = 0; k < 16; k++) begin
            repeat (CT - 1) tick();
            check($sformatf("to%0d_early", k), {timeout, db_estado}, {1'b0, 3'd1});
            tick();
            check($sformatf("to%0d_pulse", k), timeout, 1);
            check($sformatf("to%0d_estado", k), db_estado, 4);
            check($sformatf("to%0d_erros", k), db_erros, (k + 1 > 15) ? 15 : k + 1);
            tick();
            check($sformatf("to%0d_retry", k), {timeout, db_estado}, {1'b0, 3'd1});
            check($sformatf("to%0d_cont", k), db_contagem, 1);
        end

        // Play on the expiry cycle wins over the timeout.
        repeat (CT - 1) tick();
        botoes = exp_mem[1];
        tick();
        check("coinc_estado", db_estado, 2);
        check("coinc_no_to", timeout, 0);
        botoes = '0;
        tick();
        check("coinc_acertou", acertou, 1);
        check("coinc_no_to2", timeout, 0);
        check("coinc_cont", db_contagem, 2);

        // Non-one-hot play is a miss even when it equals memory; writes outside idle ignored.
        do_reset();
        modo_repete = 1'b0;
        load(0, 4'b0011);
        start(5'd1);
        load(0, 4'b1111);
        check("wr_ignored", db_esperado, 4'b0011);
        press(4'b0011);
        check("nonhot_errou", errou, 1);
        check("nonhot_acertou", acertou, 0);
        check("nonhot_estado", db_estado, 4);
        do_reset();
        load(0, exp_mem[0]);

        // Asynchronous reset mid-operation, memory retained.
        start(5'd3);
        press(exp_mem[0]);
        check("pre_rst_acertou", acertou, 1);
        reset = 1'b1;
        #1;
        check("arst_pulses", {acertou, errou, timeout, fim_sequencia}, 0);
        check("arst_estado", db_estado, 0);
        check("arst_ocupado", ocupado, 0);
        check("arst_cont", db_contagem, 0);
        check("arst_jogada", db_jogada, 0);
        check("arst_mem", db_esperado, exp_mem[0]);
        @(posedge clock);
        #1 reset = 1'b0;

        // Oversized length clamps to the full memory depth.
        start(5'd20);
        for (int i = 0; i < P; i++) begin
            press(exp_mem[i]);
            check($sformatf("clamp%0d_acertou", i), acertou, 1);
            check($sformatf("clamp%0d_fim", i), fim_sequencia, (i == P - 1));
            check($sformatf("clamp%0d_cont", i), db_contagem, (i == P - 1) ? P - 1 : i + 1);
            check($sformatf("clamp%0d_estado", i), db_estado, (i == P - 1) ? 3 : 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/teatris_sequenciador_jogadas.md
TEATRIS_SEQUENCIADOR_JOGADAS -- requirements
Module: teatris_sequenciador_jogadas

Interface
REQ-001 Parameter N_BOTOES, default 4: number of button channels; width of a play.
REQ-002 Parameter PROFUNDIDADE, default 16: number of sequence-memory entries; AW = clog2(PROFUNDIDADE).
REQ-003 Parameter CICLOS_TIMEOUT, default 5000 (>=2): maximum number of cycles allowed per play.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high; the ports are named clock and reset.
REQ-005 Port clock  in  1  rising-edge clock.
REQ-006 Port reset  in  1  asynchronous active-high reset.
REQ-007 Port botoes  in  N_BOTOES  raw button levels, already synchronous to clock.
REQ-008 Port iniciar  in  1  start request, sampled each cycle.
REQ-009 Port modo_repete  in  1  1 = after an error, retry the same address; 0 = stop.
REQ-010 Port tamanho  in  AW+1  sequence length, sampled on an accepted start.
REQ-011 Port carga_en / carga_end / carga_dado  in  1 / AW / N_BOTOES  sequence-memory write.
REQ-012 Port acertou, errou, timeout, fim_sequencia  out  1 each  one-cycle registered event pulses.
REQ-013 Port ocupado  out  1  high in ESPERA and COMPARA.
REQ-014 Port db_contagem  out  AW  current address; db_jogada  out  N_BOTOES  registered play; db_esperado  out  N_BOTOES  mem[db_contagem].
REQ-015 Port db_erros  out  4  saturating error count; db_estado  out  3  state code.

Function
REQ-016 The FSM states SHALL be encoded OCIOSO=0, ESPERA=1, COMPARA=2, FIM=3, ERRO=4.
REQ-017 Memory writes SHALL take effect on the clock edge with carga_en=1, only in state OCIOSO; otherwise they are ignored.
REQ-018 tem_jogada SHALL be combinational: (botoes != 0) && (botoes_ant == 0), where botoes_ant is botoes registered every cycle; a held button SHALL NOT retrigger.
REQ-019 Start acceptance: iniciar in OCIOSO/FIM/ERRO with tamanho != 0 SHALL take the block to ESPERA and clear the address, timer and db_erros.
REQ-020 Start rejection: iniciar with tamanho=0 SHALL be ignored, and iniciar in ESPERA/COMPARA SHALL be ignored.
REQ-021 tamanho > PROFUNDIDADE SHALL be clamped to PROFUNDIDADE.
REQ-022 In ESPERA the timer SHALL increment every cycle.
REQ-023 On tem_jogada in ESPERA, the block SHALL capture botoes into db_jogada and go to COMPARA.
REQ-024 If timer == CICLOS_TIMEOUT-1 in ESPERA with no tem_jogada, the block SHALL pulse timeout and go to ERRO.
REQ-025 If tem_jogada and timer expiry coincide, the play SHALL win.
REQ-026 COMPARA hit (db_jogada == db_esperado and db_jogada one-hot): pulse acertou; if address == tamanho-1, also pulse fim_sequencia and go to FIM; otherwise increment the address, clear the timer and go to ESPERA.
REQ-027 COMPARA miss (mismatch or non-one-hot): pulse errou and go to ERRO.
REQ-028 On entry to ERRO, db_erros SHALL increment, saturating at 15.
REQ-029 With modo_repete=1, ERRO SHALL return to ESPERA on the next cycle with the same address and the timer cleared.
REQ-030 With modo_repete=0, ERRO SHALL hold until an accepted start.
REQ-031 FIM SHALL hold until an accepted start.
REQ-032 Latency: with botoes nonzero before edge E0 (ESPERA), acertou/errou SHALL be high exactly between edges E1 and E2.
REQ-033 Timeout timing: the timeout pulse SHALL be high during the cycle after the CICLOS_TIMEOUT-th ESPERA cycle.
REQ-034 All event pulses SHALL be high for exactly one cycle.

Reset
REQ-035 Reset SHALL force state OCIOSO and clear address, timer, db_jogada, botoes_ant, db_erros and all pulses and ocupado to 0, immediately and including mid-operation.
REQ-036 Memory contents SHALL NOT be affected by reset.

Verification (N_BOTOES=4, PROFUNDIDADE=16, CICLOS_TIMEOUT=8)
REQ-037 Full sequence: load 0001,0100,1000; tamanho=3; iniciar; press each correctly -> three acertou pulses, fim_sequencia with the third, db_contagem=2, db_estado=3.
REQ-038 Wrong button: press 0010 at address 0 with modo_repete=0 -> errou pulse, db_estado=4, db_erros=1; later iniciar restarts at address 0 with db_erros=0.
REQ-039 Timeout with retry: no press for 8 cycles -> timeout pulse; with modo_repete=1, back to ESPERA at the same address; 16 consecutive timeouts leave db_erros=15.
REQ-040 Non-one-hot and held buttons: botoes=0011 -> errou even if mem=0011; holding 0001 across 5 cycles -> exactly one acertou.
REQ-041 Reset mid-ESPERA: all outputs 0 and db_estado=0 without a clock edge; memory retained (db_esperado still shows the loaded data).
REQ-042 Boundaries: iniciar with tamanho=0 -> stays OCIOSO; tamanho=20 -> fim_sequencia after the 16th hit; play coinciding with timer expiry -> acertou, no timeout.
